// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, presents it to the ITLB,
//               looks up the I-cache with the translated address, requests
//               refills through the memory arbiter on a miss and delivers one
//               instruction per cycle into IF/ID. Handles ITLB faults,
//               misaligned redirects, redirects arriving during a refill and
//               optional J/JAL predecode jumps.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_1000,
    parameter int          OFFSET         = 12,
    parameter int          PHYS_ADDR_SIZE = 20,
    parameter int          JUMP_DECODE    = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      stall_i,
    input  logic                      redirect_i,
    input  logic [31:0]               redirect_pc_i,
    output logic [31:0]               tlb_vaddr_o,
    input  logic                      tlb_ready_i,
    input  logic                      tlb_miss_i,
    input  logic [PHYS_ADDR_SIZE-1:0] tlb_paddr_i,
    output logic [PHYS_ADDR_SIZE-1:0] ic_addr_o,
    input  logic                      ic_hit_i,
    input  logic [31:0]               ic_data_i,
    output logic                      arb_req_o,
    output logic [PHYS_ADDR_SIZE-1:0] arb_addr_o,
    input  logic                      arb_ack_i,
    output logic [31:0]               inst_o,
    output logic [31:0]               inst_pc_o,
    output logic                      inst_valid_o,
    output logic                      fault_o,
    output logic [1:0]                fault_cause_o,
    output logic [31:0]               fault_pc_o
);

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        TLB_WAIT = 3'd1,
        IC_MISS  = 3'd2,
        DRAIN    = 3'd3,
        FAULT    = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_ITLB_MISS  = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b10;

    state_t      state;
    logic [31:0] pc;
    // Set when a misaligned redirect arrives while a refill is still in
    // flight: the fault state is entered only once the arbiter acknowledges.
    logic        drain_fault;

    logic [31:0]               pc_plus4;
    logic                      is_jump;
    logic [31:0]               jump_target;
    logic [31:0]               next_pc;
    logic                      redirect_misaligned;
    logic                      refill_pending;
    logic [PHYS_ADDR_SIZE-1:0] refill_addr;

    // Lookup addresses come straight from the PC and the ITLB result.
    assign tlb_vaddr_o = pc;
    assign ic_addr_o   = tlb_paddr_i;

    // Next-PC selection, including J/JAL predecode (opcodes 000010/000011).
    always_comb begin
        pc_plus4            = pc + 32'd4;
        is_jump             = (ic_data_i[31:27] == 5'b00001);
        jump_target         = {pc_plus4[31:28], ic_data_i[25:0], 2'b00};
        next_pc             = ((JUMP_DECODE != 0) && is_jump) ? jump_target : pc_plus4;
        redirect_misaligned = (redirect_pc_i[1:0] != 2'b00);
        refill_pending      = ((state == IC_MISS) || (state == DRAIN)) && !arb_ack_i;
        // Page offset is untranslated, so it is taken from the virtual PC.
        refill_addr         = {tlb_paddr_i[PHYS_ADDR_SIZE-1:OFFSET], pc[OFFSET-1:0]};
    end

    // Fetch sequencer: PC, state and every registered output.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            drain_fault   <= 1'b0;
            arb_req_o     <= 1'b0;
            arb_addr_o    <= '0;
            inst_o        <= '0;
            inst_pc_o     <= '0;
            inst_valid_o  <= 1'b0;
            fault_o       <= 1'b0;
            fault_cause_o <= '0;
            fault_pc_o    <= '0;
        end else begin
            fault_o <= 1'b0;
            if (redirect_i) begin
                pc           <= redirect_pc_i;
                inst_valid_o <= 1'b0;
                if (redirect_misaligned) begin
                    fault_o       <= 1'b1;
                    fault_cause_o <= CAUSE_MISALIGNED;
                    fault_pc_o    <= redirect_pc_i;
                end
                if (refill_pending) begin
                    // Request stays up until the ack; the refilled line is
                    // not used for the redirected fetch.
                    state       <= DRAIN;
                    drain_fault <= redirect_misaligned;
                end else begin
                    arb_req_o   <= 1'b0;
                    drain_fault <= 1'b0;
                    state       <= redirect_misaligned ? FAULT : FETCH;
                end
            end else begin
                case (state)
                    FETCH, TLB_WAIT: begin
                        if (!stall_i) begin
                            if (!tlb_ready_i) begin
                                state        <= TLB_WAIT;
                                inst_valid_o <= 1'b0;
                            end else if (tlb_miss_i) begin
                                fault_o       <= 1'b1;
                                fault_cause_o <= CAUSE_ITLB_MISS;
                                fault_pc_o    <= pc;
                                inst_valid_o  <= 1'b0;
                                state         <= FAULT;
                            end else if (ic_hit_i) begin
                                inst_o       <= ic_data_i;
                                inst_pc_o    <= pc;
                                inst_valid_o <= 1'b1;
                                pc           <= next_pc;
                                state        <= FETCH;
                            end else begin
                                arb_addr_o   <= refill_addr;
                                arb_req_o    <= 1'b1;
                                inst_valid_o <= 1'b0;
                                state        <= IC_MISS;
                            end
                        end
                    end
                    IC_MISS: begin
                        inst_valid_o <= 1'b0;
                        if (arb_ack_i) begin
                            // PC unchanged: the same address is looked up
                            // again and now hits.
                            arb_req_o <= 1'b0;
                            state     <= FETCH;
                        end
                    end
                    DRAIN: begin
                        inst_valid_o <= 1'b0;
                        if (arb_ack_i) begin
                            arb_req_o   <= 1'b0;
                            drain_fault <= 1'b0;
                            state       <= drain_fault ? FAULT : FETCH;
                        end
                    end
                    FAULT: begin
                        inst_valid_o <= 1'b0;
                    end
                    default: begin
                        inst_valid_o <= 1'b0;
                        state        <= FETCH;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit. Stimulus pushes expected
//               instructions, faults and cycle probes into queues; a single
//               monitor process pops and compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] tlb_vaddr_o;
    logic        tlb_ready_i;
    logic        tlb_miss_i;
    logic [19:0] tlb_paddr_i;
    logic [19:0] ic_addr_o;
    logic        ic_hit_i;
    logic [31:0] ic_data_i;
    logic        arb_req_o;
    logic [19:0] arb_addr_o;
    logic        arb_ack_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;
    logic [31:0] fault_pc_o;

    // Environment controls
    logic        ready_ctl;
    logic        tmiss_ctl;
    logic        miss_on;
    logic [31:0] miss_pc;
    logic        jump_on;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } inst_exp_t;

    typedef struct packed {
        logic [1:0]  cause;
        logic [31:0] pc;
    } fault_exp_t;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } probe_t;

    inst_exp_t  exp_q[$];
    fault_exp_t fq[$];
    probe_t     pq[$];

    int checks = 0;
    int errors = 0;
    logic end_req = 1'b0;
    logic done    = 1'b0;

    fetch_unit dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .tlb_vaddr_o   (tlb_vaddr_o),
        .tlb_ready_i   (tlb_ready_i),
        .tlb_miss_i    (tlb_miss_i),
        .tlb_paddr_i   (tlb_paddr_i),
        .ic_addr_o     (ic_addr_o),
        .ic_hit_i      (ic_hit_i),
        .ic_data_i     (ic_data_i),
        .arb_req_o     (arb_req_o),
        .arb_addr_o    (arb_addr_o),
        .arb_ack_i     (arb_ack_i),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_valid_o  (inst_valid_o),
        .fault_o       (fault_o),
        .fault_cause_o (fault_cause_o),
        .fault_pc_o    (fault_pc_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory image: a jump at 0x1000 when enabled, otherwise a
    // non-jump word tagged with its address.
    function automatic logic [31:0] word_at(input logic [31:0] a, input logic j);
        if (j && (a == 32'h0000_1000)) return 32'h0804_0000;
        return {8'hA5, a[23:0]};
    endfunction

    // Identity-mapped ITLB and a cache that misses only on miss_pc.
    assign tlb_ready_i = ready_ctl;
    assign tlb_miss_i  = tmiss_ctl;
    assign tlb_paddr_i = tlb_vaddr_o[19:0];
    assign ic_hit_i    = !(miss_on && (tlb_vaddr_o == miss_pc));
    assign ic_data_i   = word_at(tlb_vaddr_o, jump_on);

    function automatic logic [31:0] field(input int sel);
        case (sel)
            0:       return {31'b0, inst_valid_o};
            1:       return inst_pc_o;
            2:       return {31'b0, arb_req_o};
            3:       return {12'b0, arb_addr_o};
            4:       return {31'b0, fault_o};
            5:       return tlb_vaddr_o;
            6:       return inst_o;
            7:       return {30'b0, fault_cause_o};
            8:       return fault_pc_o;
            default: return {12'b0, ic_addr_o};
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic probe(input string name, input int sel, input logic [31:0] exp);
        probe_t p;
        p.name = name;
        p.sel  = sel;
        p.exp  = exp;
        pq.push_back(p);
    endtask

    task automatic push_inst(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back({pc, inst});
    endtask

    task automatic push_fault(input logic [1:0] cause, input logic [31:0] pc);
        fq.push_back({cause, pc});
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        step();
        redirect_i    = 1'b0;
    endtask

    // Monitor: captures inputs at the active edge, compares at the falling edge.
    initial begin
        logic        stall_prev;
        logic        ack_prev;
        logic        rst_prev;
        logic        req_prev;
        logic [19:0] addr_prev;
        inst_exp_t   e;
        fault_exp_t  f;
        probe_t      p;
        req_prev  = 1'b0;
        addr_prev = '0;
        forever begin
            @(posedge clock);
            stall_prev = stall_i;
            ack_prev   = arb_ack_i;
            rst_prev   = !reset_n;
            @(negedge clock);
            if (inst_valid_o && !stall_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_inst got pc=%h inst=%h required no instruction", inst_pc_o, inst_o);
                end else begin
                    e = exp_q.pop_front();
                    if ((inst_pc_o !== e.pc) || (inst_o !== e.inst)) begin
                        errors++;
                        $display("FAIL inst got pc=%h inst=%h required pc=%h inst=%h", inst_pc_o, inst_o, e.pc, e.inst);
                    end
                end
            end
            if (fault_o) begin
                checks++;
                if (fq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_fault got cause=%b pc=%h required no fault", fault_cause_o, fault_pc_o);
                end else begin
                    f = fq.pop_front();
                    if ((fault_cause_o !== f.cause) || (fault_pc_o !== f.pc)) begin
                        errors++;
                        $display("FAIL fault got cause=%b pc=%h required cause=%b pc=%h", fault_cause_o, fault_pc_o, f.cause, f.pc);
                    end
                end
            end
            if (req_prev) begin
                checks++;
                if (arb_req_o && (arb_addr_o !== addr_prev)) begin
                    errors++;
                    $display("FAIL arb_addr_stable got %h required %h", arb_addr_o, addr_prev);
                end else if (!arb_req_o && !ack_prev && !rst_prev) begin
                    errors++;
                    $display("FAIL arb_req_hold got 0 required 1 (no ack seen)");
                end
            end
            req_prev  = arb_req_o;
            addr_prev = arb_addr_o;
            while (pq.size() != 0) begin
                p = pq.pop_front();
                checks++;
                if (field(p.sel) !== p.exp) begin
                    errors++;
                    $display("FAIL %s got %h required %h", p.name, field(p.sel), p.exp);
                end
            end
            if (end_req && !done) begin
                checks += 2;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL inst_queue_drained got %0d left required 0", exp_q.size());
                end
                if (fq.size() != 0) begin
                    errors++;
                    $display("FAIL fault_queue_drained got %0d left required 0", fq.size());
                end
                done = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        reset_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        arb_ack_i = 1'b0; ready_ctl = 1'b0; tmiss_ctl = 1'b0;
        miss_on = 1'b0; miss_pc = '0; jump_on = 1'b0;
        step(); step();
        probe("rst_valid",    0, 32'h0);
        probe("rst_inst_pc",  1, 32'h0);
        probe("rst_arb_req",  2, 32'h0);
        probe("rst_arb_addr", 3, 32'h0);
        probe("rst_fault",    4, 32'h0);
        probe("rst_pc",       5, 32'h0000_1000);
        probe("rst_inst",     6, 32'h0);
        probe("rst_cause",    7, 32'h0);
        probe("rst_fault_pc", 8, 32'h0);

        // Sequential hits from reset
        reset_n = 1'b1; ready_ctl = 1'b1;
        push_inst(32'h1000, 32'hA500_1000);
        push_inst(32'h1004, 32'hA500_1004);
        push_inst(32'h1008, 32'hA500_1008);
        step();
        probe("hit_latency_valid", 0, 32'h1);
        probe("hit_latency_pc",    1, 32'h1000);
        step(); step();
        ready_ctl = 1'b0;
        step();
        probe("tlb_wait_bubble", 0, 32'h0);
        probe("tlb_wait_pc",     5, 32'h100C);
        probe("ic_addr",         9, 32'h0100C);

        // Cache miss at 0x1008, ack in the fifth request cycle
        do_redirect(32'h1008);
        miss_pc = 32'h1008; miss_on = 1'b1; ready_ctl = 1'b1;
        step();
        probe("miss_req",  2, 32'h1);
        probe("miss_addr", 3, 32'h01008);
        for (int i = 0; i < 4; i++) begin
            step();
            probe("miss_req_held", 2, 32'h1);
            probe("miss_bubble",   0, 32'h0);
        end
        arb_ack_i = 1'b1; miss_on = 1'b0;
        step();
        arb_ack_i = 1'b0;
        probe("ack_req_clear", 2, 32'h0);
        probe("ack_bubble",    0, 32'h0);
        push_inst(32'h1008, 32'hA500_1008);
        step();
        probe("miss_latency_valid", 0, 32'h1);
        ready_ctl = 1'b0;
        step();

        // Redirect while a refill is outstanding
        miss_pc = 32'h100C; miss_on = 1'b1; ready_ctl = 1'b1;
        step();
        probe("miss2_addr", 3, 32'h0100C);
        step();
        do_redirect(32'h2000);
        probe("drain_req_held", 2, 32'h1);
        probe("drain_pc",       5, 32'h2000);
        step(); step();
        probe("drain_req_still", 2, 32'h1);
        probe("drain_bubble",    0, 32'h0);
        arb_ack_i = 1'b1; miss_on = 1'b0;
        step();
        arb_ack_i = 1'b0;
        probe("drain_req_clear", 2, 32'h0);
        push_inst(32'h2000, 32'hA500_2000);
        step();
        ready_ctl = 1'b0;
        step();

        // ITLB miss at 0x3000, recovery by redirect to 0x8000
        do_redirect(32'h3000);
        tmiss_ctl = 1'b1; ready_ctl = 1'b1;
        push_fault(2'b01, 32'h3000);
        step();
        probe("itlb_fault_pulse", 4, 32'h1);
        tmiss_ctl = 1'b0;
        step();
        probe("itlb_fault_one_cycle", 4, 32'h0);
        step(); step();
        probe("fault_state_bubble", 0, 32'h0);
        do_redirect(32'h8000);
        push_inst(32'h8000, 32'hA500_8000);
        step();
        ready_ctl = 1'b0;
        step();

        // J/JAL predecode and misaligned redirect
        do_redirect(32'h1000);
        jump_on = 1'b1; ready_ctl = 1'b1;
        push_inst(32'h1000, 32'h0804_0000);
        push_inst(32'h0010_0000, 32'hA510_0000);
        step(); step();
        ready_ctl = 1'b0; jump_on = 1'b0;
        step();
        probe("after_jump_pc", 5, 32'h0010_0004);
        push_fault(2'b10, 32'h2002);
        do_redirect(32'h2002);
        probe("misalign_cause", 7, 32'h2);
        ready_ctl = 1'b1;
        step(); step();
        probe("misalign_no_fetch", 0, 32'h0);
        ready_ctl = 1'b0;

        // Stall freezes the stream
        do_redirect(32'h4000);
        ready_ctl = 1'b1;
        push_inst(32'h4000, 32'hA500_4000);
        push_inst(32'h4004, 32'hA500_4004);
        step(); step();
        stall_i = 1'b1;
        step();
        probe("stall_valid", 0, 32'h1);
        probe("stall_ipc",   1, 32'h4004);
        probe("stall_pc",    5, 32'h4008);
        step(); step();
        probe("stall3_ipc", 1, 32'h4004);
        probe("stall3_pc",  5, 32'h4008);
        stall_i = 1'b0;
        push_inst(32'h4008, 32'hA500_4008);
        push_inst(32'h400C, 32'hA500_400C);
        step(); step();
        ready_ctl = 1'b0;
        step();

        // PC wrap at the top of the address space
        do_redirect(32'hFFFF_FFFC);
        ready_ctl = 1'b1;
        push_inst(32'hFFFF_FFFC, 32'hA5FF_FFFC);
        push_inst(32'h0000_0000, 32'hA500_0000);
        step(); step();
        ready_ctl = 1'b0;
        step();
        probe("wrap_pc", 5, 32'h0000_0004);

        // Reset in the middle of a refill
        miss_pc = 32'h0000_0004; miss_on = 1'b1; ready_ctl = 1'b1;
        step();
        probe("pre_reset_req", 2, 32'h1);
        step();
        reset_n = 1'b0;
        step();
        probe("reset_req_clear", 2, 32'h0);
        probe("reset_pc",        5, 32'h0000_1000);
        probe("reset_valid",     0, 32'h0);
        reset_n = 1'b1; miss_on = 1'b0;
        push_inst(32'h1000, 32'hA500_1000);
        step();
        ready_ctl = 1'b0;
        step(); step();

        end_req = 1'b1;
        for (int i = 0; i < 20 && !done; i++) step();
        if (!done) begin
            $display("FAIL monitor_done got 0 required 1");
            $fatal(1, "monitor stalled");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
